serial_demux_ctrl: RTL and testbench
====================================

Name: serial_demux_ctrl

Overview:
- Sequencing controller for the serial port-demultiplexer datapath.
- Receives a framed bit stream on one serial line:
  - start bit;
  - destination port number;
  - payload length;
  - payload bits.
- Routes each payload bit to the addressed port with a registered one-hot valid.
- Also exposes the captured port and length for the seven-segment display path, plus busy/done status for the top level.

Parameters:
- PORT_W, 2, width of the port-number field; NUM_PORTS = 2**PORT_W.
- LEN_W, 4, width of the payload-length field; maximum payload is 2**LEN_W-1 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high. One clock; all state updates on the rising edge of clk.
- clk_en  in  1  bit-rate enable. The FSM and all registers advance only on cycles with clk_en=1; otherwise everything holds.
- serin  in  1  serial line; idles at 1.
- port_num  out  PORT_W  captured destination port; holds after the frame.
- num_data  out  LEN_W  captured payload length; holds after the frame.
- serout  out  1  registered copy of the current payload bit.
- p_valid  out  NUM_PORTS  one-hot; bit k=1 means serout is a valid payload bit for port k.
- busy  out  1  1 in every state except IDLE.
- done  out  1  one-clk pulse at end of frame.

Behaviour:
- Reset (rst=1 at an edge, regardless of clk_en):
  - state=IDLE;
  - port_num=0, num_data=0, serout=0, p_valid=0, done=0;
  - internal bit counter=0.
  - Reset mid-frame abandons the frame with no done pulse.
- A "step" is a rising edge with clk_en=1 and rst=0. On an edge with clk_en=0, state, counters and outputs hold, except:
  - done is cleared;
  - p_valid is cleared.
  - A valid bit is therefore presented for exactly one clk cycle.
- Bit order is MSB first for both header fields.
- States and transitions:
  - IDLE: on a step with serin=0 (start bit), go to PORT, bitcnt=PORT_W-1. serin=1 stays in IDLE.
  - PORT: each step shifts serin into port_num LSB. When bitcnt=0, go to LEN with bitcnt=LEN_W-1; otherwise decrement bitcnt.
  - LEN: each step shifts serin into num_data LSB. On the last bit (bitcnt=0):
    - if the completed length is 0, go to DONE;
    - otherwise go to DATA with the remaining-count register loaded with length-1.
  - DATA: each step registers serout<=serin and p_valid<=onehot(port_num).
    - If remaining=0, go to DONE; otherwise decrement remaining.
    - No wrap-around: the remaining count never decrements below 0.
  - DONE: on the next step assert done=1 for that cycle and return to IDLE.
    - Line content on this step is ignored; it acts as the stop slot.
    - A start bit is recognised only from the following step.
- p_valid is all-zero on every cycle outside a DATA step's output cycle.
- Latency:
  - Payload bit sampled at step n appears on serout/p_valid after that edge (one-clk registered latency).
  - Header change is visible on port_num/num_data after each shift edge.
- Header fields are cleared when a new frame's start bit is accepted. Outside PORT/LEN they hold their last value (display-stable).
- busy=1 in PORT, LEN, DATA and DONE.

Decomposition:
- Shared package:
  - state enum {IDLE, PORT, LEN, DATA, DONE} (3-bit encoding);
  - default PORT_W/LEN_W constants;
  - the onehot function.
- One natural sub-module: serial_demux_bitcnt, a loadable down-counter with a zero flag. It is reused for both header bit counting and payload counting.

Test Plan:
- Reset behaviour: clk_en=1 throughout, serin idle 1 for 5 steps, then rst=1 for 1 clk -> all outputs 0, busy=0.
- Basic frame: with clk_en=1, send serin 0 | 1 0 | 0 0 1 1 | 1 0 1 -> port_num=2, num_data=3.
  - p_valid=4'b0100 for exactly 3 cycles, with serout=1, 0, 1.
  - done pulses 1 cycle, one step after the last payload bit.
  - busy drops with done.
- Zero-length frame: 0 | 0 1 | 0 0 0 0 -> port_num=1, num_data=0.
  - p_valid never asserts; done pulses on the step after the last length bit.
- Enable gating: the basic frame with clk_en=1 only on every 4th clk -> identical field values and serout sequence.
  - Each p_valid and done is high exactly 1 clk, and no state changes on clk_en=0 cycles.
- Maximum length and port 3: 0 | 1 1 | 1 1 1 1, then 15 alternating bits -> p_valid=4'b1000 for exactly 15 steps.
  - The counter does not wrap, and there is no 16th valid.
- Reset mid-frame: assert rst during the 2nd payload bit of the basic frame -> the next edge yields IDLE with all outputs 0 and no done.
  - A new frame 0 | 0 0 | 0 0 0 1 | 1 then gives p_valid=4'b0001 once with serout=1.

Source files
------------

// File: rtl/serial_demux_pkg.sv
// -----------------------------------------------------------------------------
// serial_demux_pkg
// Shared definitions for the serial port-demultiplexer controller:
//   - default header field widths
//   - controller state encoding
//   - onehot() helper used to build the per-port valid vector
// -----------------------------------------------------------------------------
package serial_demux_pkg;

  localparam int unsigned PORT_W_DEF = 2;
  localparam int unsigned LEN_W_DEF  = 4;

  // Widest valid vector onehot() can build (5-bit index).
  localparam int unsigned ONEHOT_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [4:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/serial_demux_bitcnt.sv
// -----------------------------------------------------------------------------
// serial_demux_bitcnt
// Loadable down-counter with a zero flag. Shared by the header bit counting
// and the payload remaining-count. Decrement saturates at zero.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (count -> 0)
//   step_i     advance enable; the count holds when low
//   load_i     load load_val_i (has priority over dec_i)
//   load_val_i value to load
//   dec_i      decrement request
//   zero_o     count is zero
// -----------------------------------------------------------------------------
module serial_demux_bitcnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_demux_ctrl.sv
// -----------------------------------------------------------------------------
// serial_demux_ctrl
// Sequencing controller for the serial port demultiplexer. Parses a frame
// (start bit, port number, payload length, payload bits; headers MSB first)
// off one serial line and routes each payload bit to the addressed port with
// a registered one-hot valid.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   clk_en    bit-rate enable; the controller advances only when high
//   serin     serial line (idles at 1)
//   port_num  captured destination port (display-stable)
//   num_data  captured payload length (display-stable)
//   serout    registered copy of the current payload bit
//   p_valid   one-hot; bit k marks serout valid for port k (one clk wide)
//   busy      high in every state except IDLE
//   done      one-clk pulse at end of frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start bit (serin=0)
// PORT  | shifting in the port number
// LEN   | shifting in the payload length
// DATA  | forwarding payload bits to the addressed port
// DONE  | stop slot; pulses done and returns to IDLE
// -----------------------------------------------------------------------------
module serial_demux_ctrl
  import serial_demux_pkg::*;
#(
  parameter  int unsigned PORT_W    = PORT_W_DEF,
  parameter  int unsigned LEN_W     = LEN_W_DEF,
  localparam int unsigned NUM_PORTS = 2 ** PORT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 serin,
  output logic [PORT_W-1:0]    port_num,
  output logic [LEN_W-1:0]     num_data,
  output logic                 serout,
  output logic [NUM_PORTS-1:0] p_valid,
  output logic                 busy,
  output logic                 done
);

  // One counter covers both header bit counts and the payload count.
  localparam int unsigned CNT_W = (LEN_W > PORT_W) ? LEN_W : PORT_W;

  state_e               state_q;
  logic [PORT_W-1:0]    port_q;
  logic [PORT_W-1:0]    port_d;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_d;
  logic                 serout_q;
  logic [NUM_PORTS-1:0] p_valid_q;
  logic                 done_q;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_zero;

  // Header shift values, and the counter control for this step.
  always_comb begin
    port_d   = (port_q << 1) | PORT_W'(serin);
    len_d    = (len_q << 1) | LEN_W'(serin);
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!serin) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(PORT_W - 1);
        end
      end
      ST_PORT: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(LEN_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LEN: begin
        if (cnt_zero) begin
          // Zero-length frames skip DATA; the counter is already at 0.
          if (len_d != '0) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(len_d) - CNT_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DATA: begin
        cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  serial_demux_bitcnt #(
    .W (CNT_W)
  ) u_bitcnt (
    .clk        (clk),
    .rst        (rst),
    .step_i     (clk_en),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      len_q     <= '0;
      serout_q  <= 1'b0;
      p_valid_q <= '0;
      done_q    <= 1'b0;
    end else if (!clk_en) begin
      // Pulses last exactly one clk even when steps are sparse.
      p_valid_q <= '0;
      done_q    <= 1'b0;
    end else begin
      p_valid_q <= '0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!serin) begin
            state_q <= ST_PORT;
            port_q  <= '0;
            len_q   <= '0;
          end
        end
        ST_PORT: begin
          port_q <= port_d;
          if (cnt_zero) begin
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          len_q <= len_d;
          if (cnt_zero) begin
            state_q <= (len_d == '0) ? ST_DONE : ST_DATA;
          end
        end
        ST_DATA: begin
          serout_q  <= serin;
          p_valid_q <= NUM_PORTS'(onehot(5'(port_q)));
          if (cnt_zero) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Line value here is the stop slot and is ignored.
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign port_num = port_q;
  assign num_data = len_q;
  assign serout   = serout_q;
  assign p_valid  = p_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_demux_ctrl.sv
module tb_serial_demux_ctrl;

  localparam int PORT_W    = 2;
  localparam int LEN_W     = 4;
  localparam int NUM_PORTS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clk_en;
  logic                 serin;
  logic [PORT_W-1:0]    port_num;
  logic [LEN_W-1:0]     num_data;
  logic                 serout;
  logic [NUM_PORTS-1:0] p_valid;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  serial_demux_ctrl #(
    .PORT_W (PORT_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .serin    (serin),
    .port_num (port_num),
    .num_data (num_data),
    .serout   (serout),
    .p_valid  (p_valid),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int   port;
    logic b;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec     = 0;
  int          n_err     = 0;
  logic        mon_en    = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic [1:0]  exp_port  = '0;
  logic [3:0]  exp_len   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-clk output check; payload expectations come off the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("port_num", 32'(port_num), 32'(exp_port));
      chk("num_data", 32'(num_data), 32'(exp_len));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("p_valid", 32'(p_valid), 32'(1) << e.port);
        chk("serout", 32'(serout), 32'(e.b));
      end else begin
        chk("p_valid_idle", 32'(p_valid), 32'(0));
      end
    end
  end

  // gap disabled clks (junk on the line), then one enabled step carrying b.
  task automatic drive_step(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      clk_en = 1'b0;
      serin  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      exp_done = 1'b0;
    end
    clk_en = 1'b1;
    serin  = b;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (gap > 0) clk_en = 1'b0;
  endtask

  // data[k] is the k-th payload bit on the line. abort_at >= 0 pulses rst
  // in place of that payload step.
  task automatic send_frame(input int pnum, input int len, input logic [14:0] data,
                            input int gap, input int abort_at);
    drive_step(1'b0, gap);
    exp_busy = 1'b1;
    exp_port = '0;
    exp_len  = '0;
    for (int i = PORT_W - 1; i >= 0; i--) begin
      logic b;
      b = 1'(pnum >> i);
      drive_step(b, gap);
      exp_port = {exp_port[0], b};
    end
    for (int i = LEN_W - 1; i >= 0; i--) begin
      logic b;
      b = 1'(len >> i);
      drive_step(b, gap);
      exp_len = {exp_len[2:0], b};
    end
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        rst    = 1'b1;
        clk_en = 1'b1;
        serin  = data[k];
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_port = '0;
        exp_len  = '0;
        chk("rst_serout", 32'(serout), 32'(0));
        return;
      end
      drive_step(data[k], gap);
      sb_q.push_back('{port: pnum, b: data[k]});
    end
    // Stop slot driven low: must not be taken as a start bit.
    drive_step(1'b0, gap);
    exp_done = 1'b1;
    exp_busy = 1'b0;
    drive_step(1'b1, gap);
  endtask

  initial begin
    rst    = 1'b0;
    clk_en = 1'b1;
    serin  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_port_num", 32'(port_num), 32'(0));
    chk("rst_num_data", 32'(num_data), 32'(0));
    chk("rst_serout", 32'(serout), 32'(0));
    chk("rst_p_valid", 32'(p_valid), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    mon_en = 1'b1;
    drive_step(1'b1, 0);
    drive_step(1'b1, 0);

    send_frame(2, 3, 15'b101, 0, -1);
    chk("basic_port", 32'(port_num), 32'(2));
    chk("basic_len", 32'(num_data), 32'(3));

    send_frame(1, 0, 15'b0, 0, -1);
    chk("zero_port", 32'(port_num), 32'(1));
    chk("zero_len", 32'(num_data), 32'(0));

    send_frame(2, 3, 15'b101, 3, -1);
    chk("gated_port", 32'(port_num), 32'(2));
    chk("gated_len", 32'(num_data), 32'(3));
    drive_step(1'b1, 0);

    send_frame(3, 15, 15'h5555, 0, -1);
    chk("max_port", 32'(port_num), 32'(3));
    chk("max_len", 32'(num_data), 32'(15));
    drive_step(1'b1, 0);
    drive_step(1'b1, 0);

    send_frame(2, 3, 15'b101, 0, 1);
    drive_step(1'b1, 0);
    drive_step(1'b1, 0);
    send_frame(0, 1, 15'b1, 0, -1);
    chk("after_rst_port", 32'(port_num), 32'(0));
    chk("after_rst_len", 32'(num_data), 32'(1));

    repeat (3) drive_step(1'b1, 0);
    mon_en = 1'b0;
    chk("sb_drain", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
